// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, FSM state type and sigma functions
//
// Contents:
//   WORD_W  - word width in bits (32)
//   WIN_LEN - depth of the message-schedule sliding window (16)
//   NUM_W   - number of schedule words per block (64)
//   word_t  - one 32-bit SHA-256 word
//   state_t - message-schedule phase {LOAD, EXPAND}
//   sigma0  - ROTR7 ^ ROTR18 ^ SHR3
//   sigma1  - ROTR17 ^ ROTR19 ^ SHR10

package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int WIN_LEN = 16;
    localparam int NUM_W   = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // Rotations are written as fixed bit-field swaps so they cost only wiring.
    function automatic word_t sigma0(input word_t x);
        return {x[6:0],  x[31:7]}  ^
               {x[17:0], x[31:18]} ^
               {3'b000,  x[31:3]};
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0],   x[31:17]} ^
               {x[18:0],   x[31:19]} ^
               {10'b0,     x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_w_sum.sv
// rtl/sha256_w_sum.sv - combinational four-operand modulo-2^32 adder
//
// Ports:
//   i_a, i_b, i_c, i_d - 32-bit addends
//   o_sum              - (i_a + i_b + i_c + i_d) mod 2^32, carry-out discarded

module sha256_w_sum
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic [WORD_W-1:0] i_c,
    input  logic [WORD_W-1:0] i_d,
    output logic [WORD_W-1:0] o_sum
);

    // Sum is evaluated at word width, so overflow simply wraps.
    assign o_sum = i_a + i_b + i_c + i_d;

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule: 16 words in, W[0..63] out
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   in_valid - in_word is valid
//   in_ready - an input word is accepted this cycle (high only while loading)
//   in_word  - message word, W[0] first
//   w_valid  - w_word holds W[w_idx]
//   w_ready  - downstream consumes w_word this cycle
//   w_word   - schedule word W[t]
//   w_idx    - t, 0..63
//   w_last   - high with w_valid when t = 63
//
// All outputs are decoded from registered state only; neither in_valid nor
// w_ready reaches an output combinationally.

module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_word,
    output logic [5:0]        w_idx,
    output logic              w_last
);

    localparam logic [5:0] LAST_LOAD = 6'(WIN_LEN - 1);
    localparam logic [5:0] LAST_IDX  = 6'(NUM_W - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_cnt;
    word_t       r_win [WIN_LEN];

    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_cnt_end;
    word_t       w_s1;
    word_t       w_s0;
    word_t       w_sum;

    assign w_in_fire  = (r_state == LOAD)   && in_valid;
    assign w_out_fire = (r_state == EXPAND) && w_ready;

    // cnt counts loaded words in LOAD and is the schedule index t in EXPAND.
    assign w_cnt_end  = (r_state == LOAD) ? (r_cnt == LAST_LOAD) : (r_cnt == LAST_IDX);

    // Expansion term for t >= 16 with window[i] = W[t-16+i].
    assign w_s1 = sigma1(r_win[14]);
    assign w_s0 = sigma0(r_win[1]);

    sha256_w_sum u_w_sum (
        .i_a   (w_s1),
        .i_b   (r_win[9]),
        .i_c   (w_s0),
        .i_d   (r_win[0]),
        .o_sum (w_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_in_fire  && w_cnt_end) w_next_state = EXPAND;
            EXPAND:  if (w_out_fire && w_cnt_end) w_next_state = LOAD;
            default: w_next_state = LOAD;
        endcase
    end

    // Output decode.
    always_comb begin
        in_ready = 1'b0;
        w_valid  = 1'b0;
        w_idx    = 6'd0;
        w_last   = 1'b0;
        w_word   = '0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
            end
            EXPAND: begin
                w_valid = 1'b1;
                w_idx   = r_cnt;
                w_last  = (r_cnt == LAST_IDX);
                // The first 16 words are replayed from the window as it rotates.
                w_word  = (r_cnt[5:4] == 2'b00) ? r_win[0] : w_sum;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Shared counter for both phases; it wraps to 0 at each phase boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 6'd0;
        end else if (w_in_fire || w_out_fire) begin
            r_cnt <= w_cnt_end ? 6'd0 : r_cnt + 6'd1;
        end
    end

    // Sliding window. Every accepted transfer shifts toward slot 0; the new
    // slot-15 value is the input word while loading and the emitted word while
    // expanding (window[0] for t<16 gives the rotation, the sum for t>=16).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_in_fire || w_out_fire) begin
            for (int i = 0; i < WIN_LEN - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[WIN_LEN-1] <= w_in_fire ? in_word : w_word;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - self-checking bench for sha256_msg_schedule
`timescale 1ns/1ps

module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_idx;
    logic        w_last;

    sha256_msg_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_word   (w_word),
        .w_idx    (w_idx),
        .w_last   (w_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] blk   [16];
    logic [31:0] ref_w [64];
    logic [31:0] obs   [64];
    int          load_start_cyc;
    int          done_cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: the textbook SHA-256 recurrence over a full 64-entry array.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_ref();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) ref_w[t] = blk[t];
            else        ref_w[t] = ref_s1(ref_w[t-2]) + ref_w[t-7] + ref_s0(ref_w[t-15]) + ref_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        compute_ref();
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        compute_ref();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        compute_ref();
    endtask

    task automatic load_block(input bit gaps);
        int i = 0;
        int guard = 0;
        bit first = 1'b1;
        while (i < 16 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (first) begin
                load_start_cyc = cyc;
                first = 1'b0;
            end
            check_val("in_ready_load", in_ready, 1'b1);
            check_val("w_valid_load", w_valid, 1'b0);
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_word  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_word  = blk[i];
                i++;
            end
        end
        check_val("load_timeout", 32'(i), 32'd16);
    endtask

    task automatic run_expand(input bit bp, input bit garbage, input int abort_t);
        int t = 0;
        int guard = 0;
        while (t < 64 && guard < 2000) begin
            @(negedge clk);
            guard++;
            check_val("w_valid_expand", w_valid, 1'b1);
            check_val("in_ready_expand", in_ready, 1'b0);
            check_val($sformatf("w_word[%0d]", t), w_word, ref_w[t]);
            check_val($sformatf("w_idx[%0d]", t), w_idx, 32'(t));
            check_val($sformatf("w_last[%0d]", t), w_last, (t == 63));
            obs[t] = w_word;
            if (t == abort_t) begin
                rst      = 1'b1;
                w_ready  = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_val("abort_w_valid", w_valid, 1'b0);
                check_val("abort_in_ready", in_ready, 1'b1);
                check_val("abort_w_idx", w_idx, 6'd0);
                check_val("abort_w_word", w_word, 32'h0);
                check_val("abort_w_last", w_last, 1'b0);
                return;
            end
            w_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = garbage;
            in_word  = $urandom;
            if (w_ready) t++;
        end
        check_val("expand_timeout", 32'(t), 32'd64);
    endtask

    task automatic finish_check();
        @(negedge clk);
        done_cyc = cyc;
        in_valid = 1'b0;
        check_val("post_in_ready", in_ready, 1'b1);
        check_val("post_w_valid", w_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_word  = 32'h0;
        w_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_w_valid", w_valid, 1'b0);
        check_val("rst_w_last", w_last, 1'b0);
        check_val("rst_w_idx", w_idx, 6'd0);
        check_val("rst_w_word", w_word, 32'h0);
        rst = 1'b0;

        // "abc" block, no back-pressure, spot-check published schedule words.
        set_abc();
        load_block(1'b0);
        run_expand(1'b0, 1'b0, -1);
        finish_check();
        check_val("abc_W16", obs[16], 32'h61626380);
        check_val("abc_W17", obs[17], 32'h000F0000);
        check_val("abc_W18", obs[18], 32'h7DA86405);
        check_val("abc_W19", obs[19], 32'h600003C6);
        check_val("abc_W63", obs[63], 32'h12B1EDEB);

        // All-zero block: 80 cycles from first load to post-block idle.
        set_zero();
        load_block(1'b0);
        run_expand(1'b0, 1'b0, -1);
        finish_check();
        check_val("zero_cycles", 32'(done_cyc - load_start_cyc), 32'd80);

        // "abc" with random back-pressure and input gaps.
        set_abc();
        load_block(1'b1);
        run_expand(1'b1, 1'b0, -1);
        finish_check();

        // Garbage on in_valid/in_word throughout EXPAND.
        set_random();
        load_block(1'b0);
        run_expand(1'b0, 1'b1, -1);
        finish_check();

        // Reset after 7 loaded words; the partial block must be discarded.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_word  = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst7_in_ready", in_ready, 1'b1);
        check_val("rst7_w_valid", w_valid, 1'b0);
        set_random();
        load_block(1'b1);
        run_expand(1'b1, 1'b0, -1);
        finish_check();

        // Reset at t=30 of EXPAND, then a clean reload.
        set_random();
        load_block(1'b0);
        run_expand(1'b0, 1'b0, 30);
        set_abc();
        load_block(1'b0);
        run_expand(1'b0, 1'b0, -1);

        // Back-to-back: "abc" straight into an all-zero block.
        set_zero();
        load_block(1'b0);
        run_expand(1'b0, 1'b0, -1);
        finish_check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
